// File: rtl/lfsr_prng.sv
// Parametrised LFSR pseudo-random source, Fibonacci or Galois per step, with
// serial-to-word packing behind a valid/ready handshake and a period-wrap flag.
module lfsr_prng #(
   parameter int               WIDTH      = 16,
   parameter logic [WIDTH-1:0] TAPS       = 16'hB400,
   parameter int               OUT_W      = 8,
   parameter logic [WIDTH-1:0] RESET_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             mode,
   output logic [WIDTH-1:0] state,
   output logic             q,
   output logic [OUT_W-1:0] out_word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             wrap
);

   localparam int               CNT_W    = $clog2(OUT_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] seed_reg;
   logic [OUT_W-2:0] acc;
   logic [CNT_W-1:0] cnt;

   logic             step;
   logic             accept;
   logic             fb;
   logic [WIDTH-1:0] fib_next;
   logic [WIDTH-1:0] gal_next;
   logic [WIDTH-1:0] step_state;
   logic             step_bit;
   logic [WIDTH-1:0] seed_safe;
   logic [OUT_W-1:0] acc_ext;

   always_comb begin
      accept   = out_valid & out_ready;
      step     = en & ~load & ~(out_valid & ~out_ready);
      fb       = ^(state & TAPS);
      fib_next = {state[WIDTH-2:0], fb};
      gal_next = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? TAPS : '0);

      // A zero state can only come from a bad mask/mode pairing; kick it back to 1.
      if (state == '0) begin
         step_state = ONE;
         step_bit   = 1'b0;
      end else if (mode) begin
         step_state = gal_next;
         step_bit   = state[WIDTH-1];
      end else begin
         step_state = fib_next;
         step_bit   = fb;
      end

      seed_safe = (seed == '0) ? ONE : seed;
      acc_ext   = {acc, step_bit};
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state     <= RESET_SEED;
         seed_reg  <= RESET_SEED;
         q         <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         out_word  <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
      end else if (load) begin
         state     <= seed_safe;
         seed_reg  <= seed_safe;
         q         <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (step) begin
            state <= step_state;
            q     <= step_bit;
            wrap  <= (step_state == seed_reg);
            // A completing word overrides any acceptance in the same cycle.
            if (cnt == CNT_LAST) begin
               out_word  <= acc_ext;
               out_valid <= 1'b1;
               cnt       <= '0;
            end else begin
               acc <= acc_ext[OUT_W-2:0];
               cnt <= cnt + 1'b1;
               if (accept) out_valid <= 1'b0;
            end
         end else if (accept) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
